// File: rtl/mem_port_arbiter_if.sv
// Memory-port bundle: command/address/data toward memory, read data and busy/done back.
// The requester side drives the command (master); the arbiter or memory side answers it (slave).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4,
  parameter int FLAG_W = 2
);
  logic [FLAG_W-1:0] rw_flag;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [MASK_W-1:0] write_mask;
  logic [DATA_W-1:0] read_data;
  logic              busy;
  logic              done;

  modport master (
    output rw_flag, addr, write_data, write_mask,
    input  read_data, busy, done
  );

  modport slave (
    input  rw_flag, addr, write_data, write_mask,
    output read_data, busy, done
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory-controller port between icache (req0) and dcache (req1); MEM_ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency IDLE+ISSUE+WAIT+RESP (>=4 cycles, 3 if mem_done lands in ISSUE); mem_busy holds grants in IDLE, losers stay pending.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4,
  parameter int FLAG_W = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave  req0,
  mem_port_arbiter_if.slave  req1,
  mem_port_arbiter_if.master mem
);
  localparam logic [FLAG_W-1:0] FLAG_RD = FLAG_W'(1);
  localparam logic [FLAG_W-1:0] FLAG_WR = FLAG_W'(2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic              grant;
  logic              post_resp;
  logic              busy_q;
  logic              done0_q, done1_q;
  logic [FLAG_W-1:0] flag_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] mask_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic act0, act1, win, take, fin;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_last;
`endif

  // The requester just served sits out the IDLE cycle after RESP so it can drop rw_flag.
  assign act0 = ((req0.rw_flag == FLAG_RD) || (req0.rw_flag == FLAG_WR)) && !(post_resp && !grant);
  assign act1 = ((req1.rw_flag == FLAG_RD) || (req1.rw_flag == FLAG_WR)) && !(post_resp && grant);

  always_comb begin
    state_nxt = state;
    win       = grant;
    take      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (!mem.busy && (act0 || act1)) begin
          take      = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          win       = (act0 && act1) ? ~rr_last : act1;
`else
          win       = act1;
`endif
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
        if (mem.done) begin
          fin       = 1'b1;
          state_nxt = RESP;
        end
      end
      WAIT: begin
        if (mem.done) begin
          fin       = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= 1'b0;
      post_resp <= 1'b0;
      busy_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      flag_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state     <= state_nxt;
      busy_q    <= (state_nxt != IDLE);
      post_resp <= (state == RESP);
      done0_q   <= fin && !grant;
      done1_q   <= fin && grant;
      if (take) begin
        grant   <= win;
        flag_q  <= win ? req1.rw_flag    : req0.rw_flag;
        addr_q  <= win ? req1.addr       : req0.addr;
        wdata_q <= win ? req1.write_data : req0.write_data;
        mask_q  <= win ? req1.write_mask : req0.write_mask;
      end else if (fin) begin
        flag_q  <= '0;
      end
      if (fin && (flag_q == FLAG_RD)) begin
        if (grant) rdata1_q <= mem.read_data;
        else       rdata0_q <= mem.read_data;
      end
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     rr_last <= 1'b0;
    else if (fin) rr_last <= grant;
  end
`endif

  assign mem.rw_flag    = flag_q;
  assign mem.addr       = addr_q;
  assign mem.write_data = wdata_q;
  assign mem.write_mask = mask_q;

  assign req0.busy      = busy_q;
  assign req1.busy      = busy_q;
  assign req0.done      = done0_q;
  assign req1.done      = done1_q;
  assign req0.read_data = rdata0_q;
  assign req1.read_data = rdata1_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives both requesters and a memory responder; a transaction-timeline model predicts every output each cycle.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int FLAG_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .FLAG_W(FLAG_W)) req0_if ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .FLAG_W(FLAG_W)) req1_if ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .FLAG_W(FLAG_W)) mem_if ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .FLAG_W(FLAG_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0_if),
    .req1 (req1_if),
    .mem  (mem_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int e     = 0;

  // reference model: one outstanding transaction plus the edge at which it completed
  bit          in_txn;
  bit          t_win;
  logic [1:0]  t_flag;
  logic [31:0] t_addr, t_wd;
  logic [3:0]  t_mask;
  int          c_edge;
  bit          last;
  logic [31:0] rd_exp [2];

  // stimulus agents
  logic [1:0]  fl [2];
  logic [31:0] ad [2], wd [2];
  logic [3:0]  mk [2];
  bit          auto_req;
  int          busy_pct, lat_fix, cnt, lat;
  bit          stray_en, rd_fix_en;
  logic [31:0] rd_fix;
  int          n_done [2];
  int          done_order [$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s edge %0d: got %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  function automatic bit act(input logic [1:0] f);
    return (f == 2'd1) || (f == 2'd2);
  endfunction

  task automatic model_reset();
    in_txn = 0; t_win = 0; t_flag = 0; t_addr = 0; t_wd = 0; t_mask = 0;
    c_edge = -10; last = 0; rd_exp[0] = 0; rd_exp[1] = 0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_flag"}, 64'(mem_if.rw_flag), 0);
    check_val({tag, "_addr"}, 64'(mem_if.addr), 0);
    check_val({tag, "_wd"},   64'(mem_if.write_data), 0);
    check_val({tag, "_mask"}, 64'(mem_if.write_mask), 0);
    check_val({tag, "_busy0"}, 64'(req0_if.busy), 0);
    check_val({tag, "_busy1"}, 64'(req1_if.busy), 0);
    check_val({tag, "_done0"}, 64'(req0_if.done), 0);
    check_val({tag, "_done1"}, 64'(req1_if.done), 0);
    check_val({tag, "_rd0"},  64'(req0_if.read_data), 0);
    check_val({tag, "_rd1"},  64'(req1_if.read_data), 0);
  endtask

  task automatic cycle();
    logic [1:0]  f0, f1;
    logic [31:0] a0, a1, w0, w1, mrd;
    logic [3:0]  m0, m1;
    logic        mb, md;
    bit          el0, el1, win;
    f0 = req0_if.rw_flag; a0 = req0_if.addr; w0 = req0_if.write_data; m0 = req0_if.write_mask;
    f1 = req1_if.rw_flag; a1 = req1_if.addr; w1 = req1_if.write_data; m1 = req1_if.write_mask;
    mb = mem_if.busy; md = mem_if.done; mrd = mem_if.read_data;
    @(posedge clk);
    e++;
    if (in_txn) begin
      if (md) begin
        if (t_flag == 2'd1) rd_exp[t_win] = mrd;
        in_txn = 0; c_edge = e; last = t_win;
      end
    end else if (e >= c_edge + 2) begin
      el0 = act(f0) && !(e == c_edge + 2 && !last);
      el1 = act(f1) && !(e == c_edge + 2 && last);
      if (!mb && (el0 || el1)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win = (el0 && el1) ? !last : el1;
`else
        win = el1;
`endif
        in_txn = 1; t_win = win;
        t_flag = win ? f1 : f0; t_addr = win ? a1 : a0;
        t_wd   = win ? w1 : w0; t_mask = win ? m1 : m0;
      end
    end
    #1;
    check_val("mem_flag", 64'(mem_if.rw_flag), in_txn ? 64'(t_flag) : 64'd0);
    if (in_txn) begin
      check_val("mem_addr", 64'(mem_if.addr), 64'(t_addr));
      check_val("mem_wd",   64'(mem_if.write_data), 64'(t_wd));
      check_val("mem_mask", 64'(mem_if.write_mask), 64'(t_mask));
    end
    check_val("busy0", 64'(req0_if.busy), 64'(in_txn || e == c_edge));
    check_val("busy1", 64'(req1_if.busy), 64'(in_txn || e == c_edge));
    check_val("done0", 64'(req0_if.done), 64'(e == c_edge && !last));
    check_val("done1", 64'(req1_if.done), 64'(e == c_edge && last));
    check_val("rd0", 64'(req0_if.read_data), 64'(rd_exp[0]));
    check_val("rd1", 64'(req1_if.read_data), 64'(rd_exp[1]));
    if (req0_if.done) begin n_done[0]++; done_order.push_back(0); end
    if (req1_if.done) begin n_done[1]++; done_order.push_back(1); end
  endtask

  task automatic drive();
    logic dn [2];
    dn[0] = req0_if.done;
    dn[1] = req1_if.done;
    for (int i = 0; i < 2; i++) begin
      if (dn[i] || fl[i] == 2'd3) fl[i] = 2'd0;
      else if (auto_req && fl[i] == 2'd0 && $urandom_range(3) == 0)
        fl[i] = ($urandom_range(4) < 2) ? 2'd1 : (($urandom_range(2) < 2) ? 2'd2 : 2'd3);
      if (auto_req && $urandom_range(1) == 0) begin
        ad[i] = $urandom; wd[i] = $urandom; mk[i] = 4'($urandom);
      end
    end
    req0_if.rw_flag = fl[0]; req0_if.addr = ad[0]; req0_if.write_data = wd[0]; req0_if.write_mask = mk[0];
    req1_if.rw_flag = fl[1]; req1_if.addr = ad[1]; req1_if.write_data = wd[1]; req1_if.write_mask = mk[1];
    if (mem_if.rw_flag != 2'd0) begin
      if (cnt < 0) begin
        cnt = 0;
        lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(3));
      end else cnt++;
      mem_if.done = (cnt == lat);
    end else begin
      cnt = -1;
      mem_if.done = stray_en && ($urandom_range(5) == 0);
    end
    mem_if.busy      = (int'($urandom_range(99)) < busy_pct);
    mem_if.read_data = rd_fix_en ? rd_fix : $urandom;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      drive();
      cycle();
    end
  endtask

  initial begin
    int  base0, base1;
    bit  exp_first;
    for (int i = 0; i < 2; i++) begin fl[i] = 0; ad[i] = 0; wd[i] = 0; mk[i] = 0; end
    auto_req = 0; busy_pct = 0; lat_fix = 1; cnt = -1; lat = 0;
    stray_en = 0; rd_fix_en = 0; rd_fix = 0; n_done[0] = 0; n_done[1] = 0;
    req0_if.rw_flag = 0; req0_if.addr = 0; req0_if.write_data = 0; req0_if.write_mask = 0;
    req1_if.rw_flag = 0; req1_if.addr = 0; req1_if.write_data = 0; req1_if.write_mask = 0;
    mem_if.read_data = 0; mem_if.busy = 0; mem_if.done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst = 1'b1;

    // single read, memory answers 3 cycles after ISSUE
    lat_fix = 3; rd_fix_en = 1; rd_fix = 32'hDEAD_BEEF;
    fl[0] = 2'd1; ad[0] = 32'h0000_1000;
    base0 = n_done[0]; base1 = n_done[1];
    run(10);
    check_val("read_done0_cnt", 64'(n_done[0] - base0), 1);
    check_val("read_done1_cnt", 64'(n_done[1] - base1), 0);
    check_val("read_data", 64'(req0_if.read_data), 64'h0000_0000_DEAD_BEEF);

    // write from the data cache
    lat_fix = 1;
    fl[1] = 2'd2; ad[1] = 32'h2004; wd[1] = 32'h1234_5678; mk[1] = 4'b0011;
    base1 = n_done[1];
    run(8);
    check_val("write_done1_cnt", 64'(n_done[1] - base1), 1);
    check_val("write_rd1_kept", 64'(req1_if.read_data), 0);

    // repeated simultaneous reads: order must alternate
    done_order.delete();
    exp_first = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_first = !last;
`endif
    for (int r = 0; r < 3; r++) begin
      lat_fix = r % 2;
      fl[0] = 2'd1; fl[1] = 2'd1; ad[0] = 32'h300 + r; ad[1] = 32'h400 + r;
      run(14);
    end
    check_val("tie_count", 64'(done_order.size()), 6);
    if (done_order.size() > 0) check_val("tie_first", 64'(done_order[0]), 64'(exp_first));
    for (int k = 1; k < done_order.size(); k++)
      check_val("tie_alt", 64'(done_order[k]), 64'(!done_order[k-1]));

    // memory busy with stray done pulses: nothing may issue
    busy_pct = 100; stray_en = 1; rd_fix_en = 0;
    fl[0] = 2'd2; fl[1] = 2'd1; ad[0] = 32'h500; ad[1] = 32'h600;
    base0 = n_done[0]; base1 = n_done[1];
    run(8);
    check_val("bp_no_done", 64'((n_done[0] - base0) + (n_done[1] - base1)), 0);
    busy_pct = 0; stray_en = 0;
    run(16);
    check_val("bp_served", 64'((n_done[0] - base0) + (n_done[1] - base1)), 2);

    // asynchronous reset while waiting on memory
    lat_fix = 3; fl[0] = 2'd1; ad[0] = 32'h40;
    run(2);
    #2 rst = 1'b0;
    #1 check_zero("arst");
    fl[0] = 0; fl[1] = 0;
    req0_if.rw_flag = 0; req1_if.rw_flag = 0; mem_if.done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    model_reset();
    cnt = -1;
    mem_if.done = 1'b1;
    cycle();
    fl[0] = 2'd1; ad[0] = 32'h80; lat_fix = 2;
    base0 = n_done[0];
    run(10);
    check_val("post_rst_done0", 64'(n_done[0] - base0), 1);

    // fields changed after grant must not reach memory
    lat_fix = 3; fl[0] = 2'd1; ad[0] = 32'h100;
    run(2);
    ad[0] = 32'h200;
    run(8);

    // randomized traffic
    auto_req = 1; busy_pct = 20; lat_fix = -1; stray_en = 1; rd_fix_en = 0;
    run(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
